// File: rtl/s_des_ctrl.sv
// Simplified-DES block controller: key schedule, initial/final permutation and
// round sequencing around an external combinational Fk round unit.
module s_des_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       decrypt_i,
  input  logic [9:0] key_in_i,
  input  logic [7:0] din_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] dout_o,
  output logic [7:0] fk_ip_o,
  output logic [7:0] fk_key_o,
  input  logic [7:0] fk_res_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_KEY  = 3'd1;
  localparam logic [2:0] S_R1   = 3'd2;
  localparam logic [2:0] S_R2   = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  typedef struct packed {
    logic       dec;
    logic [9:0] key;
    logic [7:0] blk;
  } req_t;

  // Permutation position 1 is the MSB, so position n maps to bit W-n.
  function automatic logic [9:0] p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] k);
    return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] b);
    return {b[6], b[2], b[5], b[7], b[4], b[0], b[3], b[1]};
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] b);
    return {b[4], b[7], b[5], b[3], b[1], b[6], b[0], b[2]};
  endfunction

  logic [2:0] state_q, state_d;
  req_t       req_q, req_d;
  logic [7:0] k1_q, k1_d, k2_q, k2_d;
  logic [7:0] st_q, st_d;
  logic [7:0] dout_q, dout_d;
  logic       done_q, done_d;

  logic [9:0] key_p10, key_ls1, key_ls3;

  // K2 uses a further 2-bit rotate of the LS-1 halves (3 bits total).
  always_comb begin
    key_p10 = p10(req_q.key);
    key_ls1 = {key_p10[8:5], key_p10[9], key_p10[3:0], key_p10[4]};
    key_ls3 = {key_ls1[7:5], key_ls1[9:8], key_ls1[2:0], key_ls1[4:3]};
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    k1_d     = k1_q;
    k2_d     = k2_q;
    st_d     = st_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    fk_ip_o  = 8'h00;
    fk_key_o = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          req_d   = {decrypt_i, key_in_i, din_i};
          state_d = S_KEY;
        end
      end
      S_KEY: begin
        k1_d    = p8(key_ls1);
        k2_d    = p8(key_ls3);
        st_d    = ip(req_q.blk);
        state_d = S_R1;
      end
      S_R1: begin
        fk_ip_o  = st_q;
        fk_key_o = req_q.dec ? k2_q : k1_q;
        st_d     = {fk_res_i[3:0], fk_res_i[7:4]};
        state_d  = S_R2;
      end
      S_R2: begin
        fk_ip_o  = st_q;
        fk_key_o = req_q.dec ? k1_q : k2_q;
        st_d     = fk_res_i;
        state_d  = S_OUT;
      end
      S_OUT: begin
        dout_d  = ip_inv(st_q);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      k1_q    <= 8'h00;
      k2_q    <= 8'h00;
      st_q    <= 8'h00;
      dout_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      st_q    <= st_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign dout_o = dout_q;

endmodule

// File: tb/tb_s_des_ctrl.sv
// Directed bench for s_des_ctrl with a selectable Fk stub (identity or ip^key).
module tb_s_des_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, decrypt;
  logic [9:0] key_in;
  logic [7:0] din;
  logic       busy, done;
  logic [7:0] dout, fk_ip, fk_key, fk_res;
  logic       xor_mode;

  int tests = 0;
  int fails = 0;

  s_des_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .decrypt_i(decrypt),
    .key_in_i(key_in), .din_i(din), .busy_o(busy), .done_o(done),
    .dout_o(dout), .fk_ip_o(fk_ip), .fk_key_o(fk_key), .fk_res_i(fk_res)
  );

  always #5 clk = ~clk;

  always_comb fk_res = xor_mode ? (fk_ip ^ fk_key) : fk_ip;

  typedef struct {
    logic       dec;
    logic [9:0] key;
    logic [7:0] din;
    logic       xm;
    logic [7:0] kr1, kr2, ip1, ip2, dout;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full operation; inputs are scrambled while busy to show they are ignored.
  task automatic run_op(input vec_t v);
    @(negedge clk);
    decrypt = v.dec; key_in = v.key; din = v.din; xor_mode = v.xm; start = 1'b1;
    chk("idle_busy", busy, 0);
    @(negedge clk);
    start = 1'b0; decrypt = ~v.dec; key_in = ~v.key; din = ~v.din;
    chk("key_busy", busy, 1);
    chk("key_fk_ip", fk_ip, 0);
    chk("key_fk_key", fk_key, 0);
    @(negedge clk);
    chk("r1_fk_ip", fk_ip, v.ip1);
    chk("r1_fk_key", fk_key, v.kr1);
    @(negedge clk);
    chk("r2_fk_ip", fk_ip, v.ip2);
    chk("r2_fk_key", fk_key, v.kr2);
    @(negedge clk);
    chk("out_fk_ip", fk_ip, 0);
    chk("out_done", done, 0);
    chk("out_busy", busy, 1);
    @(negedge clk);
    chk("done", done, 1);
    chk("dout", dout, v.dout);
    chk("done_busy", busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("dout_hold", dout, v.dout);
  endtask

  initial begin
    int n;
    int seen;
    //           dec   key            din           xm    kr1    kr2    ip1    ip2    dout
    vecs[0] = '{1'b0, 10'b1010000010, 8'b10010111, 1'b0, 8'hA4, 8'h43, 8'h5D, 8'hD5, 8'hC7};
    vecs[1] = '{1'b1, 10'b1010000010, 8'b10010111, 1'b0, 8'h43, 8'hA4, 8'h5D, 8'hD5, 8'hC7};
    vecs[2] = '{1'b0, 10'b1010000010, 8'b10010111, 1'b1, 8'hA4, 8'h43, 8'h5D, 8'h9F, 8'hD5};
    vecs[3] = '{1'b0, 10'b1111111111, 8'hFF,       1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    vecs[4] = '{1'b1, 10'b0000000001, 8'h01,       1'b1, 8'h08, 8'h02, 8'h04, 8'hC0, 8'h4C};

    rst = 1'b1; start = 1'b0; decrypt = 1'b0; key_in = '0; din = '0; xor_mode = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dout", dout, 0);
    chk("rst_fk_ip", fk_ip, 0);
    chk("rst_fk_key", fk_key, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_op(vecs[i]);

    // start pulsed during R1 and R2 is ignored
    @(negedge clk);
    decrypt = 1'b0; key_in = 10'b1010000010; din = 8'b10010111; xor_mode = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; chk("ign_r1_busy", busy, 1);
    @(negedge clk); start = 1'b1; chk("ign_r2_busy", busy, 1);
    @(negedge clk); start = 1'b0; chk("ign_out_busy", busy, 1);
    @(negedge clk); chk("ign_done", done, 1); chk("ign_dout", dout, 8'hC7);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("ign_no_extra", seen, 0);

    // reset during R2 aborts the block
    @(negedge clk);
    decrypt = 1'b0; key_in = 10'b1010000010; din = 8'b10010111; xor_mode = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("abort_in_r2", fk_ip, 8'h9F); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_dout", dout, 0);
    chk("abort_done", done, 0);
    chk("abort_fk_key", fk_key, 0);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    run_op(vecs[4]);

    // start held high: one block every 5 cycles, dout per block
    @(negedge clk);
    decrypt = 1'b0; key_in = 10'b1010000010; din = 8'b10010111; xor_mode = 1'b0; start = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 12);
    chk("b2b_lat1", n, 5);
    chk("b2b_dout1", dout, 8'hC7);
    din = 8'h01;
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 12);
    chk("b2b_lat2", n, 5);
    chk("b2b_dout2", dout, 8'h04);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_pulse", done, 0);
    chk("b2b_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
